// File: rtl/store_merge_unit.sv
// Sub-word store merger: turns SB/SH into read-modify-write on a word-only
// data memory; word stores go straight to a single write.
module store_merge_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  StoreReq,
  input  logic [1:0]            StoreSize,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  AlignErr,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [31:0]           MemWriteData,
  input  logic [31:0]           MemReadData
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WAIT, S_WRITE} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t                state;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [1:0]            a_size;
  logic [31:0]           a_wdata;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] waddr;

  assign waddr = {a_addr[ADDR_WIDTH-1:2], 2'b00};

  function automatic logic illegal(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b11) || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction

  // Little-endian lane insert; bits of wd above the store size are dropped.
  function automatic logic [31:0] merge(input logic [31:0] rd, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = rd;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0: m[7:0]   = wd[7:0];
        2'd1: m[15:8]  = wd[7:0];
        2'd2: m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      m[31:16] = wd[15:0];
    end else begin
      m[15:0] = wd[15:0];
    end
    return m;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      a_addr       <= '0;
      a_size       <= '0;
      a_wdata      <= '0;
      cnt          <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      AlignErr     <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
    end else begin
      Done     <= 1'b0;
      AlignErr <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (StoreReq) begin
            a_addr   <= Address;
            a_size   <= StoreSize;
            a_wdata  <= WriteData;
            // Error pulse is registered so it lands exactly on the CHECK cycle.
            AlignErr <= illegal(StoreSize, Address[1:0]);
            Busy     <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (AlignErr) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else if (a_size == SZ_WORD) begin
            MemWrite     <= 1'b1;
            Done         <= 1'b1;
            MemAddress   <= waddr;
            MemWriteData <= a_wdata;
            state        <= S_WRITE;
          end else begin
            MemRead    <= 1'b1;
            MemAddress <= waddr;
            state      <= S_READ;
          end
        end
        S_READ: begin
          cnt   <= 3'(READ_LATENCY);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 3'd1) begin
            MemWriteData <= merge(MemReadData, a_wdata, a_size, a_addr[1:0]);
            MemWrite     <= 1'b1;
            Done         <= 1'b1;
            state        <= S_WRITE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_WRITE: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench: one DUT at READ_LATENCY=1 (index 0), one at 3 (index 1),
// each backed by a delayed-response word memory model.
module tb_store_merge_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  req;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy[2], done[2], aerr[2], mrd[2], mwr[2];
  logic [31:0] maddr[2], mwd[2], mrdata[2];
  logic [31:0] memword[2];
  logic [3:0]  vp0 = '0, vp1 = '0;
  int          pass = 0, total = 0;

  always #5 Clk = ~Clk;

  store_merge_unit #(.ADDR_WIDTH(32), .READ_LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .StoreReq(req[0]), .StoreSize(size), .Address(addr),
    .WriteData(wdata), .Busy(busy[0]), .Done(done[0]), .AlignErr(aerr[0]),
    .MemAddress(maddr[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .MemWriteData(mwd[0]), .MemReadData(mrdata[0]));

  store_merge_unit #(.ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .StoreReq(req[1]), .StoreSize(size), .Address(addr),
    .WriteData(wdata), .Busy(busy[1]), .Done(done[1]), .AlignErr(aerr[1]),
    .MemAddress(maddr[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .MemWriteData(mwd[1]), .MemReadData(mrdata[1]));

  // Read data is valid only READ_LATENCY cycles after the strobe; garbage otherwise.
  always @(posedge Clk) begin
    vp0 <= {vp0[2:0], mrd[0]};
    vp1 <= {vp1[2:0], mrd[1]};
  end
  assign mrdata[0] = vp0[0] ? memword[0] : 32'hBADBADBA;
  assign mrdata[1] = vp1[2] ? memword[1] : 32'hBADBADBA;

  task automatic issue(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(negedge Clk);
    req[d] = 1'b1; size = sz; addr = a; wdata = wd;
    @(posedge Clk);
    #1 req[d] = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy[d], done[d], aerr[d], mrd[d], mwr[d]} !== 5'b0)
        $display("FAIL reset_ctl dut%0d got %b want 00000", d, {busy[d], done[d], aerr[d], mrd[d], mwr[d]});
      else pass++;
      total++;
      if (maddr[d] !== 32'h0) $display("FAIL reset_maddr dut%0d got %h want 0", d, maddr[d]);
      else pass++;
      total++;
      if (mwd[d] !== 32'h0) $display("FAIL reset_mwd dut%0d got %h want 0", d, mwd[d]);
      else pass++;
    end
    Reset = 1'b0;
  endtask

  task automatic test_word;
    logic [3:0] ectl;
    issue(0, 2'b00, 32'h10, 32'hDEADBEEF);
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      ectl = {c <= 2, c == 2, 1'b0, c == 2};
      total++;
      if ({busy[0], done[0], mrd[0], mwr[0]} !== ectl)
        $display("FAIL word_ctl c%0d got %b want %b", c, {busy[0], done[0], mrd[0], mwr[0]}, ectl);
      else pass++;
      if (c == 2) begin
        total++;
        if (maddr[0] !== 32'h10 || mwd[0] !== 32'hDEADBEEF)
          $display("FAIL word_data got %h/%h want 00000010/deadbeef", maddr[0], mwd[0]);
        else pass++;
      end
    end
  endtask

  task automatic test_subword(input int d, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mem,
                              input logic [31:0] exp, input bit poke, input string name);
    int dc;
    logic [3:0] ectl;
    dc = d ? 6 : 4;
    memword[d] = mem;
    issue(d, sz, a, wd);
    for (int c = 1; c <= dc + 2; c++) begin
      @(negedge Clk);
      ectl = {c <= dc, c == dc, c == 2, c == dc};
      total++;
      if ({busy[d], done[d], mrd[d], mwr[d]} !== ectl)
        $display("FAIL %s_ctl c%0d got %b want %b", name, c, {busy[d], done[d], mrd[d], mwr[d]}, ectl);
      else pass++;
      if (c == 2) begin
        total++;
        if (maddr[d] !== {a[31:2], 2'b00}) $display("FAIL %s_raddr got %h want %h", name, maddr[d], {a[31:2], 2'b00});
        else pass++;
      end
      if (c == dc) begin
        total++;
        if (maddr[d] !== {a[31:2], 2'b00} || mwd[d] !== exp)
          $display("FAIL %s_write got %h/%h want %h/%h", name, maddr[d], mwd[d], {a[31:2], 2'b00}, exp);
        else pass++;
      end
      if (poke && c == 3) begin
        req[d] = 1'b1; size = 2'b00; addr = 32'h40; wdata = 32'hAAAAAAAA;
      end
      if (poke && c == 4) req[d] = 1'b0;
    end
  endtask

  task automatic test_align_err;
    logic [1:0]  szv[3];
    logic [31:0] av[3];
    logic [4:0]  ectl;
    szv[0] = 2'b01; av[0] = 32'h21;
    szv[1] = 2'b00; av[1] = 32'h26;
    szv[2] = 2'b11; av[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      issue(0, szv[i], av[i], 32'h12345678);
      for (int c = 1; c <= 2; c++) begin
        @(negedge Clk);
        ectl = (c == 1) ? 5'b11000 : 5'b00000;
        total++;
        if ({busy[0], aerr[0], mrd[0], mwr[0], done[0]} !== ectl)
          $display("FAIL alignerr_%0d c%0d got %b want %b", i, c, {busy[0], aerr[0], mrd[0], mwr[0], done[0]}, ectl);
        else pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    issue(0, 2'b00, 32'h2C, 32'h0BADF00D);
    @(negedge Clk);
    @(negedge Clk);
    total++;
    if (done[0] !== 1'b1 || mwd[0] !== 32'h0BADF00D) $display("FAIL b2b_first got %b/%h want 1/0badf00d", done[0], mwd[0]);
    else pass++;
    @(negedge Clk);
    total++;
    if (busy[0] !== 1'b0) $display("FAIL b2b_gap busy got %b want 0", busy[0]);
    else pass++;
    req[0] = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'h12345678;
    @(posedge Clk);
    #1 req[0] = 1'b0;
    @(negedge Clk);
    total++;
    if ({busy[0], done[0]} !== 2'b10) $display("FAIL b2b_check got %b want 10", {busy[0], done[0]});
    else pass++;
    @(negedge Clk);
    total++;
    if (done[0] !== 1'b1 || mwr[0] !== 1'b1 || maddr[0] !== 32'h30 || mwd[0] !== 32'h12345678)
      $display("FAIL b2b_second got %b%b/%h/%h want 11/00000030/12345678", done[0], mwr[0], maddr[0], mwd[0]);
    else pass++;
  endtask

  task automatic test_reset_mid;
    memword[1] = 32'h0;
    issue(1, 2'b10, 32'h20, 32'h77);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    total++;
    if ({busy[1], done[1], mwr[1]} !== 3'b000) $display("FAIL rstmid_now got %b want 000", {busy[1], done[1], mwr[1]});
    else pass++;
    for (int c = 5; c <= 8; c++) begin
      @(negedge Clk);
      total++;
      if ({busy[1], mwr[1]} !== 2'b00) $display("FAIL rstmid_after c%0d got %b want 00", c, {busy[1], mwr[1]});
      else pass++;
    end
    issue(1, 2'b00, 32'h44, 32'hCAFEF00D);
    @(negedge Clk);
    @(negedge Clk);
    total++;
    if (mwr[1] !== 1'b1 || done[1] !== 1'b1 || maddr[1] !== 32'h44 || mwd[1] !== 32'hCAFEF00D)
      $display("FAIL rstmid_sw got %b%b/%h/%h want 11/00000044/cafef00d", mwr[1], done[1], maddr[1], mwd[1]);
    else pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; req = 2'b00; size = 2'b00; addr = '0; wdata = '0;
    memword[0] = '0; memword[1] = '0;
    test_reset;
    test_word;
    test_subword(0, 2'b10, 32'h22, 32'hFFFFFFAB, 32'h11223344, 32'h11AB3344, 1'b0, "sb");
    test_subword(0, 2'b01, 32'h22, 32'h0000CAFE, 32'h11223344, 32'hCAFE3344, 1'b0, "sh_hi");
    test_subword(0, 2'b01, 32'h20, 32'h0000CAFE, 32'h11223344, 32'h1122CAFE, 1'b0, "sh_lo");
    test_align_err;
    test_subword(1, 2'b10, 32'h23, 32'h00000055, 32'h00000000, 32'h55000000, 1'b1, "sb_lat3");
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
